// File: rtl/arcade_input_mapper.sv
// Player-input front end: decodes ps2_key into held keys, merges MiSTer joysticks, remaps orientation,
// cleans opposing directions and stretches coin presses. Optional autofire via ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input_mapper #(
    parameter int NPLAYERS   = 2,
    parameter int COIN_PULSE = 600000,
    parameter int AF_HALF    = 400000
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [10:0]            ps2_key,
    input  logic [16*NPLAYERS-1:0] joystick,
    input  logic                   rotate,
    input  logic                   autofire_en,
    output logic [8*NPLAYERS-1:0]  player_out,
    output logic                   service
);
    localparam int COIN_W = $clog2(COIN_PULSE + 1);
    localparam logic [COIN_W-1:0] COIN_LOAD = COIN_W'(COIN_PULSE);
    localparam logic [COIN_W-1:0] COIN_ONE  = COIN_W'(1);

    if (NPLAYERS < 1 || NPLAYERS > 4) begin : g_bad_nplayers
        $error("arcade_input_mapper: NPLAYERS must be in 1..4");
    end

    logic                toggle_q;
    logic [8:0]          kb_p1;
    logic [7:0]          kb_p2;
    logic                kb_service;
    logic [7:0]          kb_p1_byte;
    logic [7:0]          merged    [NPLAYERS];
    logic [7:0]          out_next  [NPLAYERS];
    logic [COIN_W-1:0]   coin_cnt  [NPLAYERS];
    logic [COIN_W-1:0]   coin_next [NPLAYERS];
    logic [NPLAYERS-1:0] coin_prev;
    logic                fire_gate;
    logic                up, down, left, right;

    // kb_p1 keeps the two fire keys apart: [3:0] U/D/L/R as R,L,D,U, [4] space, [5] ctrl, [6] fire2, [7] start, [8] coin
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            toggle_q   <= ps2_key[10];
            kb_p1      <= '0;
            kb_p2      <= '0;
            kb_service <= 1'b0;
        end else if (ps2_key[10] != toggle_q) begin
            toggle_q <= ps2_key[10];
            case ({ps2_key[8], ps2_key[7:0]})
                9'h174: kb_p1[0] <= ps2_key[9];
                9'h16B: kb_p1[1] <= ps2_key[9];
                9'h172: kb_p1[2] <= ps2_key[9];
                9'h175: kb_p1[3] <= ps2_key[9];
                9'h029: kb_p1[4] <= ps2_key[9];
                9'h014: kb_p1[5] <= ps2_key[9];
                9'h011: kb_p1[6] <= ps2_key[9];
                9'h016: kb_p1[7] <= ps2_key[9];
                9'h02E: kb_p1[8] <= ps2_key[9];
                9'h034: kb_p2[0] <= ps2_key[9];
                9'h023: kb_p2[1] <= ps2_key[9];
                9'h02B: kb_p2[2] <= ps2_key[9];
                9'h02D: kb_p2[3] <= ps2_key[9];
                9'h01C: kb_p2[4] <= ps2_key[9];
                9'h01B: kb_p2[5] <= ps2_key[9];
                9'h01E: kb_p2[6] <= ps2_key[9];
                9'h036: kb_p2[7] <= ps2_key[9];
                9'h02C: kb_service <= ps2_key[9];
                default: ;
            endcase
        end
    end

    assign kb_p1_byte = {kb_p1[8], kb_p1[7], kb_p1[6], kb_p1[4] | kb_p1[5], kb_p1[3:0]};

    always_comb begin
        up    = 1'b0;
        down  = 1'b0;
        left  = 1'b0;
        right = 1'b0;
        for (int p = 0; p < NPLAYERS; p++) begin
            merged[p] = joystick[16*p +: 8];
            if (p == 0)
                merged[p] = merged[p] | kb_p1_byte;
            else if (p == 1)
                merged[p] = merged[p] | kb_p2;

            up    = rotate ? merged[p][1] : merged[p][3];
            down  = rotate ? merged[p][0] : merged[p][2];
            left  = rotate ? merged[p][2] : merged[p][1];
            right = rotate ? merged[p][3] : merged[p][0];
            if (up && down) begin
                up   = 1'b0;
                down = 1'b0;
            end
            if (left && right) begin
                left  = 1'b0;
                right = 1'b0;
            end

            // a running pulse swallows any new edge, so holding or re-pressing cannot extend it
            if (coin_cnt[p] != '0)
                coin_next[p] = coin_cnt[p] - COIN_ONE;
            else if (merged[p][7] && !coin_prev[p])
                coin_next[p] = COIN_LOAD;
            else
                coin_next[p] = '0;

            out_next[p] = {merged[p][5], coin_next[p] != '0, merged[p][6],
                           merged[p][4] & fire_gate, up, down, left, right};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            player_out <= '0;
            service    <= 1'b0;
            coin_prev  <= '0;
            for (int p = 0; p < NPLAYERS; p++)
                coin_cnt[p] <= '0;
        end else begin
            service <= kb_service;
            for (int p = 0; p < NPLAYERS; p++) begin
                coin_cnt[p]             <= coin_next[p];
                coin_prev[p]            <= merged[p][7];
                player_out[8*p +: 8]    <= out_next[p];
            end
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int AF_W = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;
    localparam logic [AF_W-1:0] AF_LAST = AF_W'(AF_HALF - 1);
    localparam logic [AF_W-1:0] AF_ONE  = AF_W'(1);

    logic [AF_W-1:0] af_cnt;
    logic            af_phase;

    // one free-running phase shared by all players so their autofire stays in step
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            af_cnt   <= '0;
            af_phase <= 1'b1;
        end else if (af_cnt == AF_LAST) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt <= af_cnt + AF_ONE;
        end
    end

    assign fire_gate = af_phase | ~autofire_en;
`else
    localparam int unused_af_half = AF_HALF;
    assign fire_gate = 1'b1;
`endif

    logic unused_bits;
    assign unused_bits = ^{joystick, autofire_en};
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: joystick/rotate vector table plus keyboard, coin,
// reset and autofire sequences (autofire cadence only checked when ARCADE_INPUT_AUTOFIRE_EN is defined).
module tb_arcade_input_mapper;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [47:0] joystick;
    logic        rotate;
    logic        autofire_en;
    logic [23:0] player_out;
    logic        service;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [47:0] joy;
        logic        rot;
        logic [23:0] exp;
    } vec_t;

    vec_t        vecs [11];
    logic [12:0] coin_in_seq;
    logic [12:0] coin_exp_seq;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic [19:0] fire_seq;
    int          run_len;
    int          transitions;
    int          bad_runs;
`endif

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .NPLAYERS  (3),
        .COIN_PULSE(5),
        .AF_HALF   (3)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_key    (ps2_key),
        .joystick   (joystick),
        .rotate     (rotate),
        .autofire_en(autofire_en),
        .player_out (player_out),
        .service    (service)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [47:0] joy, input logic rot);
        joystick = joy;
        rotate   = rot;
        tick();
    endtask

    task automatic sendKey(input logic ext, input logic [7:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, ext, code};
        tick();
    endtask

    initial begin
        vecs[0]  = '{"idle",          48'h0000_0000_0000, 1'b0, 24'h000000};
        vecs[1]  = '{"p1_up",         48'h0000_0000_0008, 1'b0, 24'h000008};
        vecs[2]  = '{"p1_up_rot",     48'h0000_0000_0008, 1'b1, 24'h000001};
        vecs[3]  = '{"p1_ud_rot",     48'h0000_0000_000C, 1'b1, 24'h000000};
        vecs[4]  = '{"p1_ud",         48'h0000_0000_000C, 1'b0, 24'h000000};
        vecs[5]  = '{"p1_lr",         48'h0000_0000_0003, 1'b0, 24'h000000};
        vecs[6]  = '{"p1_buttons",    48'h0000_0000_0070, 1'b0, 24'h0000B0};
        vecs[7]  = '{"p2_left_rot",   48'h0000_0002_0000, 1'b1, 24'h000800};
        vecs[8]  = '{"p3_down_f2_rot",48'h0024_0000_0000, 1'b1, 24'h820000};
        vecs[9]  = '{"p1_right_hi",   48'h0000_0000_FF01, 1'b1, 24'h000004};
        vecs[10] = '{"p1_ul_rot",     48'h0000_0000_000A, 1'b1, 24'h000009};
        coin_in_seq  = 13'b1111110111101;
        coin_exp_seq = 13'b0111110011111;

        reset       = 1'b1;
        ps2_key     = '0;
        joystick    = '0;
        rotate      = 1'b0;
        autofire_en = 1'b0;
        tick();
        tick();
        checkOutput("reset_player_out", 32'(player_out), 32'h0);
        checkOutput("reset_service", 32'(service), 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].joy, vecs[i].rot);
            checkOutput(vecs[i].name, 32'(player_out), 32'(vecs[i].exp));
        end
        applyStimulus(48'h0, 1'b0);

        sendKey(1'b1, 8'h75, 1'b1);
        checkOutput("kb_up_lat1", 32'(player_out[3]), 32'h0);
        tick();
        checkOutput("kb_up_lat2", 32'(player_out[3]), 32'h1);
        ps2_key = {ps2_key[10], 1'b0, 1'b1, 8'h75};
        tick();
        tick();
        checkOutput("kb_no_toggle", 32'(player_out[3]), 32'h1);
        sendKey(1'b1, 8'h75, 1'b0);
        checkOutput("kb_up_rel_lat1", 32'(player_out[3]), 32'h1);
        tick();
        checkOutput("kb_up_rel_lat2", 32'(player_out[3]), 32'h0);

        sendKey(1'b1, 8'h29, 1'b1);
        sendKey(1'b0, 8'h55, 1'b1);
        tick();
        checkOutput("kb_ext_unmapped", 32'(player_out), 32'h0);
        checkOutput("kb_unmapped_service", 32'(service), 32'h0);
        sendKey(1'b1, 8'h29, 1'b0);
        sendKey(1'b0, 8'h55, 1'b0);

        sendKey(1'b0, 8'h29, 1'b1);
        sendKey(1'b0, 8'h14, 1'b1);
        tick();
        checkOutput("fire_both", 32'(player_out[4]), 32'h1);
        sendKey(1'b0, 8'h29, 1'b0);
        tick();
        checkOutput("fire_ctrl_only", 32'(player_out[4]), 32'h1);
        sendKey(1'b0, 8'h14, 1'b0);
        tick();
        checkOutput("fire_none", 32'(player_out[4]), 32'h0);

        sendKey(1'b0, 8'h1C, 1'b1);
        sendKey(1'b0, 8'h2C, 1'b1);
        tick();
        checkOutput("kb_p2_fire", 32'(player_out), 32'h001000);
        checkOutput("kb_service", 32'(service), 32'h1);
        sendKey(1'b0, 8'h1C, 1'b0);
        sendKey(1'b0, 8'h2C, 1'b0);
        tick();
        checkOutput("kb_p2_release", 32'(player_out), 32'h0);
        checkOutput("kb_service_release", 32'(service), 32'h0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(48'h0000_0080_0000, 1'b0);
            checkOutput($sformatf("coin_held_%0d", i), 32'(player_out[14]), (i < 5) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 3; i++)
            applyStimulus(48'h0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(coin_in_seq[i] ? 48'h0000_0080_0000 : 48'h0, 1'b0);
            checkOutput($sformatf("coin_repress_%0d", i), 32'(player_out[14]), 32'(coin_exp_seq[i]));
        end
        applyStimulus(48'h0, 1'b0);

        sendKey(1'b1, 8'h75, 1'b1);
        sendKey(1'b0, 8'h2C, 1'b1);
        applyStimulus(48'h0000_0080_0000, 1'b0);
        checkOutput("pre_reset_out", 32'(player_out), 32'h004008);
        checkOutput("pre_reset_service", 32'(service), 32'h1);
        reset    = 1'b1;
        joystick = '0;
        ps2_key  = {~ps2_key[10], 1'b1, 1'b1, 8'h75};
        tick();
        checkOutput("reset_mid_out", 32'(player_out), 32'h0);
        checkOutput("reset_mid_service", 32'(service), 32'h0);
        reset = 1'b0;
        tick();
        tick();
        checkOutput("post_reset_out", 32'(player_out), 32'h0);
        checkOutput("post_reset_service", 32'(service), 32'h0);
        sendKey(1'b1, 8'h75, 1'b1);
        tick();
        checkOutput("post_reset_press", 32'(player_out), 32'h000008);
        sendKey(1'b1, 8'h75, 1'b0);
        tick();

        autofire_en = 1'b1;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        for (int i = 0; i < 20; i++) begin
            applyStimulus(48'h0000_0000_0010, 1'b0);
            fire_seq[i] = player_out[4];
        end
        run_len     = 1;
        transitions = 0;
        bad_runs    = 0;
        for (int i = 1; i < 20; i++) begin
            if (fire_seq[i] == fire_seq[i-1]) begin
                run_len++;
            end else begin
                if (transitions > 0 && run_len != 3)
                    bad_runs++;
                transitions++;
                run_len = 1;
            end
        end
        checkOutput("af_run_length", 32'(bad_runs), 32'h0);
        checkOutput("af_toggles", (transitions >= 5) ? 32'h1 : 32'h0, 32'h1);
        autofire_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(48'h0000_0000_0010, 1'b0);
            checkOutput($sformatf("af_off_fire_%0d", i), 32'(player_out[4]), 32'h1);
        end
`else
        for (int i = 0; i < 8; i++) begin
            applyStimulus(48'h0000_0000_0010, 1'b0);
            checkOutput($sformatf("af_absent_fire_%0d", i), 32'(player_out[4]), 32'h1);
        end
`endif
        applyStimulus(48'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
